// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode bring-up sequencer.
// Command bytes carry the 0x40 start/transmission prefix.
package sd_pkg;

   typedef enum logic [2:0] {
      StPwrup,
      StCmd0,
      StCmd8,
      StCmd55,
      StAcmd41,
      StReady,
      StCmd17,
      StError
   } state_e;

   typedef enum logic [2:0] {
      ErrNone   = 3'd0,
      ErrNoResp = 3'd1,
      ErrCmd0   = 3'd2,
      ErrCmd8   = 3'd3,
      ErrRetry  = 3'd4,
      ErrAcmd41 = 3'd5
   } err_code_e;

   localparam logic [7:0]  CmdGoIdle      = 8'h40;
   localparam logic [7:0]  CmdSendIfCond  = 8'h48;
   localparam logic [7:0]  CmdReadBlock   = 8'h51;
   localparam logic [7:0]  CmdAppCmd      = 8'h77;
   localparam logic [7:0]  CmdSdSendOpCnd = 8'h69;

   localparam logic [7:0]  CrcCmd0  = 8'h95;
   localparam logic [7:0]  CrcCmd8  = 8'h87;
   localparam logic [7:0]  CrcDummy = 8'hFF;

   localparam logic [31:0] ArgCmd8   = 32'h0000_01AA;
   localparam logic [31:0] ArgAcmd41 = 32'h4000_0000;

   localparam logic [7:0]  RespNone = 8'hFF;

   function automatic logic is_cmd_state(input state_e s);
      return s inside {StCmd0, StCmd8, StCmd55, StAcmd41, StCmd17};
   endfunction

endpackage

// File: rtl/sd_init_seq.sv
// SD SPI-mode bring-up sequencer (CMD0/CMD8/CMD55+ACMD41) and CMD17 single-block read front end.
// Every command state runs an ISSUE phase (cmd_start high) followed by a GAP phase that re-arms the engine.
module sd_init_seq
   import sd_pkg::*;
#(
   parameter int unsigned POWERUP_CYCLES = 80,
   parameter int unsigned GAP_CYCLES     = 8,
   parameter int unsigned RETRY_MAX      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic        rd_ack,
   output logic [31:0] rd_data,
   output logic        rd_err,
   output logic        init_done,
   output logic        busy,
   output logic        error,
   output logic [2:0]  err_code,
   output logic [7:0]  retry_cnt,
   output logic        cs_n,
   output logic [7:0]  cmd_number,
   output logic [31:0] cmd_args,
   output logic [7:0]  cmd_crc,
   output logic        cmd_start,
   input  logic        cmd_done,
   input  logic [7:0]  resp_flags,
   input  logic [31:0] data_word
);

   state_e      state_q, state_d;
   state_e      nxt_q, nxt_d;
   logic        gap_q, gap_d;
   logic [15:0] cnt_q, cnt_d;
   err_code_e   err_q, err_d;
   logic [7:0]  retry_q, retry_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;

   logic        last_pwr;
   logic        last_gap;
   logic [8:0]  attempt;
   err_code_e   fail_code;

   assign last_pwr = (cnt_q == 16'(POWERUP_CYCLES - 1));
   assign last_gap = (cnt_q == 16'(GAP_CYCLES - 1));
   assign attempt  = {1'b0, retry_q} + 9'd1;

   always_comb begin
      state_d   = state_q;
      nxt_d     = nxt_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      retry_d   = retry_q;
      addr_d    = addr_q;
      rdata_d   = rdata_q;
      rerr_d    = rerr_q;
      fail_code = ErrNone;

      case (state_q)
         StPwrup: begin
            cnt_d = cnt_q + 16'd1;
            if (last_pwr) begin
               state_d = StCmd0;
               cnt_d   = '0;
            end
         end
         StReady: begin
            if (rd_req) begin
               addr_d  = rd_addr;
               state_d = StCmd17;
               gap_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         StError: ;
         default: begin
            if (gap_q) begin
               cnt_d = cnt_q + 16'd1;
               if (last_gap) begin
                  state_d = nxt_q;
                  gap_d   = 1'b0;
                  cnt_d   = '0;
               end
            end else if (cmd_done) begin
               gap_d = 1'b1;
               cnt_d = '0;
               case (state_q)
                  StCmd0: begin
                     if (resp_flags == 8'h01) nxt_d = StCmd8;
                     else fail_code = (resp_flags == RespNone) ? ErrNoResp : ErrCmd0;
                  end
                  StCmd8: begin
                     if (resp_flags == 8'h01 || resp_flags == 8'h05) nxt_d = StCmd55;
                     else fail_code = (resp_flags == RespNone) ? ErrNoResp : ErrCmd8;
                  end
                  StCmd55: begin
                     if (resp_flags == 8'h00 || resp_flags == 8'h01) nxt_d = StAcmd41;
                     else fail_code = (resp_flags == RespNone) ? ErrNoResp : ErrAcmd41;
                  end
                  StAcmd41: begin
                     retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                     if (resp_flags == 8'h00) begin
                        nxt_d = StReady;
                     end else if (resp_flags == 8'h01) begin
                        if (attempt < 9'(RETRY_MAX)) nxt_d = StCmd55;
                        else fail_code = ErrRetry;
                     end else begin
                        fail_code = (resp_flags == RespNone) ? ErrNoResp : ErrAcmd41;
                     end
                  end
                  StCmd17: begin
                     nxt_d = StReady;
                     if (resp_flags == 8'h00) begin
                        rdata_d = data_word;
                        rerr_d  = 1'b0;
                     end else begin
                        rerr_d  = 1'b1;
                     end
                  end
                  default: ;
               endcase
               // Init failures skip the gap: the engine is idled by entering ERROR.
               if (fail_code != ErrNone) begin
                  state_d = StError;
                  err_d   = fail_code;
                  gap_d   = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StPwrup;
         nxt_q   <= StPwrup;
         gap_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= ErrNone;
         retry_q <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nxt_q   <= nxt_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         retry_q <= retry_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   always_comb begin
      cmd_number = 8'h00;
      cmd_args   = 32'h0;
      cmd_crc    = CrcDummy;
      case (state_q)
         StCmd0: begin
            cmd_number = CmdGoIdle;
            cmd_crc    = CrcCmd0;
         end
         StCmd8: begin
            cmd_number = CmdSendIfCond;
            cmd_args   = ArgCmd8;
            cmd_crc    = CrcCmd8;
         end
         StCmd55: cmd_number = CmdAppCmd;
         StAcmd41: begin
            cmd_number = CmdSdSendOpCnd;
            cmd_args   = ArgAcmd41;
         end
         StCmd17: begin
            cmd_number = CmdReadBlock;
            cmd_args   = addr_q;
         end
         default: ;
      endcase
   end

   assign cmd_start = is_cmd_state(state_q) && !gap_q;
   assign cs_n      = !is_cmd_state(state_q);
   assign init_done = (state_q == StReady) || (state_q == StCmd17);
   assign busy      = (state_q != StReady) && (state_q != StError);
   assign error     = (state_q == StError);
   assign err_code  = err_q;
   assign retry_cnt = retry_q;
   assign rd_ack    = (state_q == StCmd17) && gap_q && last_gap;
   assign rd_data   = rdata_q;
   assign rd_err    = rerr_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Self-checking bench for sd_init_seq: a scripted card model answers the engine handshake and a
// rule-level predictor supplies the expected init outcome and read results.
module tb_sd_init_seq;

   localparam int unsigned PwrupCycles = 80;
   localparam int unsigned GapCycles   = 8;
   localparam int unsigned RetryMax    = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        rd_req = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        rd_ack, rd_err, init_done, busy, error, cs_n, cmd_start;
   logic [31:0] rd_data, cmd_args;
   logic [2:0]  err_code;
   logic [7:0]  retry_cnt, cmd_number, cmd_crc;
   logic        cmd_done;
   logic [7:0]  resp_flags;
   logic [31:0] data_word;

   sd_init_seq #(
      .POWERUP_CYCLES(PwrupCycles),
      .GAP_CYCLES    (GapCycles),
      .RETRY_MAX     (RetryMax)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .rd_err    (rd_err),
      .init_done (init_done),
      .busy      (busy),
      .error     (error),
      .err_code  (err_code),
      .retry_cnt (retry_cnt),
      .cs_n      (cs_n),
      .cmd_number(cmd_number),
      .cmd_args  (cmd_args),
      .cmd_crc   (cmd_crc),
      .cmd_start (cmd_start),
      .cmd_done  (cmd_done),
      .resp_flags(resp_flags),
      .data_word (data_word)
   );

   // Second instance with a tiny retry budget and an always-busy card.
   logic        reset_r = 1'b1;
   logic        rd_ack_r, rd_err_r, init_done_r, busy_r, error_r, cs_n_r, cmd_start_r;
   logic [31:0] rd_data_r, cmd_args_r;
   logic [2:0]  err_code_r;
   logic [7:0]  retry_cnt_r, cmd_number_r, cmd_crc_r;
   logic        cmd_done_r = 1'b0;
   int          n_acmd_r = 0;

   sd_init_seq #(
      .POWERUP_CYCLES(16),
      .GAP_CYCLES    (4),
      .RETRY_MAX     (3)
   ) u_dut_r3 (
      .clk       (clk),
      .reset     (reset_r),
      .rd_req    (1'b0),
      .rd_addr   (32'h0),
      .rd_ack    (rd_ack_r),
      .rd_data   (rd_data_r),
      .rd_err    (rd_err_r),
      .init_done (init_done_r),
      .busy      (busy_r),
      .error     (error_r),
      .err_code  (err_code_r),
      .retry_cnt (retry_cnt_r),
      .cs_n      (cs_n_r),
      .cmd_number(cmd_number_r),
      .cmd_args  (cmd_args_r),
      .cmd_crc   (cmd_crc_r),
      .cmd_start (cmd_start_r),
      .cmd_done  (cmd_done_r),
      .resp_flags(8'h01),
      .data_word (32'h0)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Card script
   logic [7:0]  r0, r8, r55, racmd_final, r17;
   int          nbusy;
   logic [31:0] d17, cur_addr;
   int          acmd_k = 0;
   int          n17 = 0;

   task automatic respond();
      cmd_done  = 1'b1;
      data_word = $urandom;
      case (cmd_number)
         8'h40: begin
            resp_flags = r0;
            check("cmd0_args", cmd_args, 32'h0);
            check("cmd0_crc", 32'(cmd_crc), 32'h95);
         end
         8'h48: begin
            resp_flags = r8;
            check("cmd8_args", cmd_args, 32'h1AA);
            check("cmd8_crc", 32'(cmd_crc), 32'h87);
         end
         8'h77: begin
            resp_flags = r55;
            check("cmd55_args", cmd_args, 32'h0);
            check("cmd55_crc", 32'(cmd_crc), 32'hFF);
         end
         8'h69: begin
            acmd_k++;
            resp_flags = (acmd_k <= nbusy) ? 8'h01 : racmd_final;
            check("acmd41_args", cmd_args, 32'h4000_0000);
            check("acmd41_crc", 32'(cmd_crc), 32'hFF);
         end
         8'h51: begin
            n17++;
            resp_flags = r17;
            data_word  = d17;
            check("cmd17_args", cmd_args, cur_addr);
            check("cmd17_crc", 32'(cmd_crc), 32'hFF);
         end
         default: check("cmd_number_valid", 32'(cmd_number), 32'h51);
      endcase
   endtask

   initial begin : card
      int lat;
      bit pend;
      cmd_done   = 1'b0;
      resp_flags = 8'h00;
      data_word  = '0;
      lat  = 0;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cmd_done = 1'b0;
            pend     = 1'b0;
            acmd_k   = 0;
         end else if (cmd_done) begin
            cmd_done  = 1'b0;
            data_word = $urandom;
         end else if (pend) begin
            lat--;
            if (lat == 0) begin
               pend = 1'b0;
               respond();
            end
         end else if (cmd_start) begin
            pend = 1'b1;
            lat  = $urandom_range(2, 5);
         end
      end
   end

   initial begin : card_r3
      forever begin
         @(negedge clk);
         if (reset_r || cmd_done_r) begin
            cmd_done_r = 1'b0;
         end else if (cmd_start_r) begin
            cmd_done_r = 1'b1;
            if (cmd_number_r == 8'h69) n_acmd_r++;
         end
      end
   end

   // Expected init outcome from the bring-up rules.
   task automatic predict(output logic e, output logic [2:0] code, output logic [7:0] rc);
      logic [7:0] resp;
      e    = 1'b1;
      rc   = 8'd0;
      code = 3'd0;
      if (r0 != 8'h01) begin
         code = (r0 == 8'hFF) ? 3'd1 : 3'd2;
         return;
      end
      if (!(r8 == 8'h01 || r8 == 8'h05)) begin
         code = (r8 == 8'hFF) ? 3'd1 : 3'd3;
         return;
      end
      for (int k = 1; k <= 300; k++) begin
         if (!(r55 == 8'h00 || r55 == 8'h01)) begin
            code = (r55 == 8'hFF) ? 3'd1 : 3'd5;
            return;
         end
         resp = (k <= nbusy) ? 8'h01 : racmd_final;
         rc   = (k > 255) ? 8'd255 : 8'(k);
         if (resp == 8'h00) begin
            e = 1'b0;
            return;
         end else if (resp == 8'h01) begin
            if (k >= int'(RetryMax)) begin
               code = 3'd4;
               return;
            end
         end else begin
            code = (resp == 8'hFF) ? 3'd1 : 3'd5;
            return;
         end
      end
   endtask

   logic [31:0] exp_data;

   task automatic run_init();
      logic       e;
      logic [2:0] code;
      logic [7:0] rc;
      int         n;
      logic       seen;
      rd_req = 1'b0;
      reset  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_cmd_start", 32'(cmd_start), 32'd0);
      check("rst_cmd_number", 32'(cmd_number), 32'h0);
      check("rst_cmd_args", cmd_args, 32'h0);
      check("rst_cmd_crc", 32'(cmd_crc), 32'hFF);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_error", 32'(error), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_retry_cnt", 32'(retry_cnt), 32'd0);
      check("rst_rd_ack", 32'(rd_ack), 32'd0);
      check("rst_rd_err", 32'(rd_err), 32'd0);
      check("rst_rd_data", rd_data, 32'h0);
      exp_data = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (cs_n && n < 1000) begin
         if (cmd_start) n = 2000;
         n++;
         @(negedge clk);
      end
      check("pwrup_cs_n_cycles", 32'(n), 32'(PwrupCycles));
      n = 0;
      while (!(init_done || error) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("init_finished", 32'(init_done | error), 32'd1);
      predict(e, code, rc);
      check("init_error", 32'(error), 32'(e));
      check("init_err_code", 32'(err_code), 32'(code));
      check("init_retry_cnt", 32'(retry_cnt), 32'(rc));
      check("init_done", 32'(init_done), 32'(!e));
      check("init_busy", 32'(busy), 32'd0);
      if (error) begin
         seen = 1'b0;
         repeat (20) begin
            @(negedge clk);
            seen = seen | cmd_start | ~cs_n | ~error;
         end
         check("error_idle", 32'(seen), 32'd0);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] resp);
      int n;
      cur_addr = addr;
      d17      = data;
      r17      = resp;
      n17      = 0;
      if (resp == 8'h00) exp_data = data;
      @(negedge clk);
      rd_addr = addr;
      rd_req  = 1'b1;
      @(negedge clk);
      rd_addr = $urandom;
      n = 0;
      while (!rd_ack && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("rd_ack_seen", 32'(rd_ack), 32'd1);
      check("rd_data", rd_data, exp_data);
      check("rd_err", 32'(rd_err), 32'(resp != 8'h00));
      check("rd_cmd17_count", 32'(n17), 32'd1);
      rd_req = 1'b0;
      @(negedge clk);
      check("rd_ack_pulse", 32'(rd_ack), 32'd0);
      check("rd_back_ready", 32'(init_done & ~busy), 32'd1);
   endtask

   function automatic logic [7:0] odd_resp();
      case ($urandom_range(0, 3))
         0: return 8'hFF;
         1: return 8'h04;
         2: return 8'h00;
         default: return 8'(($urandom_range(2, 254)));
      endcase
   endfunction

   initial begin : main
      int n;
      logic [7:0] rr;
      r0 = 8'h01; r8 = 8'h01; r55 = 8'h01; racmd_final = 8'h00; nbusy = 3;
      r17 = 8'h00; d17 = '0; cur_addr = '0;

      run_init();
      do_read(32'h0000_0010, 32'hDEAD_BEEF, 8'h00);
      do_read(32'h0000_0020, 32'h1234_5678, 8'h04);
      for (int i = 0; i < 6; i++) begin
         rr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         do_read($urandom, $urandom, rr);
      end

      r0 = 8'hFF;
      run_init();

      for (int i = 0; i < 8; i++) begin
         r0  = ($urandom_range(0, 4) == 0) ? odd_resp() : 8'h01;
         r8  = ($urandom_range(0, 4) == 0) ? odd_resp() : (($urandom_range(0, 1) == 0) ? 8'h01 : 8'h05);
         r55 = ($urandom_range(0, 4) == 0) ? odd_resp() : (($urandom_range(0, 1) == 0) ? 8'h01 : 8'h00);
         racmd_final = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h04) : 8'h00;
         nbusy = $urandom_range(0, 5);
         run_init();
         if (init_done) do_read($urandom, $urandom, 8'h00);
      end

      // Reset while the second ACMD41 is being issued.
      r0 = 8'h01; r8 = 8'h01; r55 = 8'h01; racmd_final = 8'h00; nbusy = 3;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (!(cmd_start && cmd_number == 8'h69 && acmd_k == 1 && !cmd_done) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("mid_acmd41_reached", 32'(cmd_start), 32'd1);
      check("mid_retry_before", 32'(retry_cnt), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_cmd_start", 32'(cmd_start), 32'd0);
      check("mid_rst_cs_n", 32'(cs_n), 32'd1);
      check("mid_rst_retry_cnt", 32'(retry_cnt), 32'd0);
      run_init();

      reset_r = 1'b1;
      repeat (3) @(negedge clk);
      reset_r = 1'b0;
      n = 0;
      while (!error_r && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("r3_error", 32'(error_r), 32'd1);
      check("r3_err_code", 32'(err_code_r), 32'd4);
      check("r3_retry_cnt", 32'(retry_cnt_r), 32'd3);
      check("r3_acmd41_count", 32'(n_acmd_r), 32'd3);
      check("r3_busy", 32'(busy_r), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
